// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw level and only follows it after STABLE_CYCLES consecutive agreeing samples
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic sample_en,
  output logic db_level,
  output logic busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, diff, last, db_d;
  assign s    = sync[SYNC_STAGES-1];
  assign diff = s != db_level;
  assign last = cnt == CNT_W'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      db_level <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw_in};
      state    <= state_d;
      cnt      <= cnt_d;
      db_level <= db_d;
    end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    db_d    = db_level;
    if (sample_en) begin
      state_d = (diff && !(state == WAIT && last)) ? WAIT : IDLE;
      cnt_d   = (state_d == WAIT) ? ((state == WAIT) ? cnt + 1'b1 : CNT_W'(1)) : '0;
      db_d    = db_level ^ (state == WAIT && diff && last);
    end
  end
  assign busy = state == WAIT;
endmodule
